// File: rtl/mac_accum.sv
// Streaming signed accumulator behind the multiplier.
// Sums product beats per group and presents a registered result.
module mac_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int CNT_WIDTH = 8,
  parameter bit SAT       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam int M = ACC_WIDTH - 1;

  localparam logic [ACC_WIDTH-1:0] AMAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] AMIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] oacc_q, oacc_d;
  logic [CNT_WIDTH-1:0] ocnt_q, ocnt_d;
  logic                 oovf_q, oovf_d;

  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] sum_fix;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 add_ovf;
  logic                 accept;
  logic                 consume;

  assign out_valid = (state_q == HOLD);
  assign in_ready  = ~clear & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  assign out_acc   = oacc_q;
  assign out_count = ocnt_q;
  assign out_ovf   = oovf_q;

  // Sign-extend the product and detect signed overflow of the add.
  assign addend  = ACC_WIDTH'($signed(in_product));
  assign sum     = acc_q + addend;
  assign add_ovf = (acc_q[M] == addend[M]) &&
                   (sum[M] != acc_q[M]);

  assign cnt_inc = (cnt_q == '1) ? cnt_q
                 : cnt_q + CNT_WIDTH'(1);

  // Clamp toward the addend's sign when saturating.
  always_comb begin
    sum_fix = sum;
    if (SAT && add_ovf) begin
      sum_fix = addend[M] ? AMIN : AMAX;
    end
  end

  // Next-state for the group accumulator, output register and FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    oacc_d  = oacc_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;

    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept) begin
      if (in_last) begin
        oacc_d = sum_fix;
        ocnt_d = cnt_inc;
        oovf_d = ovf_q | add_ovf;
        acc_d  = '0;
        cnt_d  = '0;
        ovf_d  = 1'b0;
      end else begin
        acc_d = sum_fix;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | add_ovf;
      end
    end

    unique case (state_q)
      ACCUM: begin
        if (accept && in_last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (consume && !(accept && in_last)) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      oacc_q  <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      oacc_q  <= oacc_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: directed and random groups
// checked against an integer reference model.
module tb_mac_accum;

  localparam int W  = 8;
  localparam int AW = 20;
  localparam int CW = 8;
  localparam int AMAX = (1 << (AW-1)) - 1;
  localparam int AMIN = -(1 << (AW-1));

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] in_product;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int checks;
  int failures;

  int macc;
  int mcnt;
  bit movf;
  int e_acc;
  int e_cnt;
  bit e_ovf;

  mac_accum #(
    .WIDTH(W), .ACC_WIDTH(AW),
    .CNT_WIDTH(CW), .SAT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count),
    .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    macc = 0;
    mcnt = 0;
    movf = 1'b0;
  endtask

  // Group arithmetic: exact integer sum, clamped into range.
  task automatic model_beat(input logic [2*W-1:0] p,
                            input bit last);
    int v;
    v = int'($signed(p));
    macc = macc + v;
    if (macc > AMAX) begin
      macc = AMAX;
      movf = 1'b1;
    end else if (macc < AMIN) begin
      macc = AMIN;
      movf = 1'b1;
    end
    if (mcnt < (1 << CW) - 1) mcnt++;
    if (last) begin
      e_acc = macc & ((1 << AW) - 1);
      e_cnt = mcnt;
      e_ovf = movf;
      model_reset();
    end
  endtask

  task automatic beat(input logic [2*W-1:0] p,
                      input bit last);
    int n;
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      chk("beat_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk);
      model_beat(p, last);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_acc"},   32'(out_acc),   32'(e_acc));
    chk({tag, "_cnt"},   32'(out_count), 32'(e_cnt));
    chk({tag, "_ovf"},   32'(out_ovf),   32'(e_ovf));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_acc"},   32'(out_acc),   32'd0);
    chk({tag, "_cnt"},   32'(out_count), 32'd0);
    chk({tag, "_ovf"},   32'(out_ovf),   32'd0);
  endtask

  initial begin
    logic [AW-1:0] held;
    int len;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_product = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    model_reset();
    e_acc = 0;
    e_cnt = 0;
    e_ovf = 1'b0;

    // Reset state
    #2;
    chk_zero("rst");
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // 1: 10, -3, 7(last)
    beat(16'd10, 1'b0);
    beat(-16'sd3, 1'b0);
    beat(16'd7, 1'b1);
    chk_out("t1");
    chk("t1_acc14", 32'(out_acc), 32'd14);
    chk("t1_cnt3", 32'(out_count), 32'd3);
    @(posedge clk);
    #1;
    chk("t1_drop", 32'(out_valid), 32'd0);

    // 2: backpressure holds output stable
    out_ready = 1'b0;
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b1);
    chk_out("t2");
    held = out_acc;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t2_hold_v", 32'(out_valid), 32'd1);
      chk("t2_hold_a", 32'(out_acc), 32'(held));
      chk("t2_inrdy0", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t2_inrdy1", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("t2_drop", 32'(out_valid), 32'd0);

    // 3: saturation both directions
    for (int i = 0; i < 40; i++) begin
      beat(16'h4000, i == 39);
    end
    chk_out("t3p");
    chk("t3p_max", 32'(out_acc), 32'h7FFFF);
    chk("t3p_cnt", 32'(out_count), 32'd40);
    for (int i = 0; i < 40; i++) begin
      beat(16'hC000, i == 39);
    end
    chk_out("t3n");
    chk("t3n_min", 32'(out_acc), 32'h80000);

    // 4: single most-negative beat, then back-to-back random groups
    beat(16'h8000, 1'b1);
    chk_out("t4s");
    chk("t4s_acc", 32'(out_acc), 32'hF8000);
    chk("t4s_cnt", 32'(out_count), 32'd1);
    for (int g = 0; g < 12; g++) begin
      len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        beat(16'($urandom), b == len - 1);
      end
      chk_out("t4r");
    end
    @(posedge clk);
    #1;
    chk("t4_drop", 32'(out_valid), 32'd0);

    // Idle: no spurious output
    repeat (4) @(posedge clk);
    #1;
    chk("idle_v", 32'(out_valid), 32'd0);

    // 5: clear drops the open group and the offered beat
    beat(16'd5, 1'b0);
    beat(16'd6, 1'b0);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_product = 16'd100;
    #1;
    chk("t5_inrdy", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    beat(16'd9, 1'b1);
    chk_out("t5");
    chk("t5_acc9", 32'(out_acc), 32'd9);
    @(posedge clk);
    #1;

    // 6: async reset mid-group and while holding
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    rst = 1'b1;
    #1;
    chk_zero("t6a");
    #1;
    rst = 1'b0;
    model_reset();
    out_ready = 1'b0;
    beat(16'd5, 1'b1);
    chk_out("t6h");
    rst = 1'b1;
    #1;
    chk_zero("t6b");
    #1;
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b1);
    chk_out("t6");
    chk("t6_acc3", 32'(out_acc), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
